// File: rtl/resline_renderer.sv
// Resolution-label overlay: fetches one bitmap ROM row per video line and
// serialises it MSB-first onto the raster with x/y pixel replication.
module resline_renderer #(
    parameter int LINE_WIDTH = 136,
    parameter int X_POS      = 16,
    parameter int Y_POS      = 16,
    parameter int SCALE      = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic [11:0]           counterY,
    input  logic [11:0]           counterX,
    input  logic                  de_in,
    output logic [3:0]            rom_addr,
    input  logic [LINE_WIDTH-1:0] rom_q,
    output logic                  pixel_on,
    output logic                  fetch_err
);

    localparam int BW = $clog2(LINE_WIDTH);
    localparam logic [11:0]   Y_LO     = 12'(Y_POS);
    localparam logic [11:0]   Y_HI     = 12'(Y_POS + 16 * SCALE);
    localparam logic [11:0]   X_LO     = 12'(X_POS);
    localparam logic [1:0]    REP_LAST = 2'(SCALE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(LINE_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, ARMED, SHIFT} state_t;

    state_t                state, state_nxt;
    logic [3:0]            row_idx, row_nxt;
    logic [1:0]            sub, sub_nxt;
    logic [1:0]            rep;
    logic [BW-1:0]         bit_cnt;
    logic [LINE_WIDTH-1:0] shift_reg;
    logic                  blank;
    logic                  in_win, at_start, strobe, rep_wrap, last, early;

    assign in_win   = (counterY >= Y_LO) && (counterY < Y_HI);
    assign at_start = de_in && (counterX == X_LO);
    // line_start pre-empts any pixel strobe in the same cycle
    assign strobe   = !line_start &&
                      ((state == ARMED && at_start && !blank) || (state == SHIFT && de_in));
    assign rep_wrap = (rep == REP_LAST);
    assign last     = rep_wrap && (bit_cnt == BIT_LAST);
    assign early    = !line_start && at_start && (state == ADDR || state == WAIT);

    // Row/sub-line tracking; only committed on an in-window line_start.
    always_comb begin
        row_nxt = row_idx;
        sub_nxt = sub;
        if (counterY == Y_LO) begin
            row_nxt = '0;
            sub_nxt = '0;
        end else if (sub == REP_LAST) begin
            sub_nxt = '0;
            row_nxt = row_idx + 4'd1;
        end else begin
            sub_nxt = sub + 2'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (line_start) begin
            state_nxt = in_win ? ADDR : IDLE;
        end else begin
            case (state)
                ADDR:    state_nxt = WAIT;
                WAIT:    state_nxt = ARMED;
                ARMED:   if (strobe) state_nxt = last ? IDLE : SHIFT;
                SHIFT:   if (strobe && last) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            row_idx   <= '0;
            sub       <= '0;
            rep       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            blank     <= 1'b0;
            rom_addr  <= '0;
            pixel_on  <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pixel_on  <= strobe & shift_reg[LINE_WIDTH-1];
            fetch_err <= early;
            if (line_start) begin
                rep     <= '0;
                bit_cnt <= '0;
                blank   <= 1'b0;
                if (in_win) begin
                    row_idx  <= row_nxt;
                    sub      <= sub_nxt;
                    rom_addr <= row_nxt;
                end
            end else begin
                // a late fetch blanks the rest of the line but the load still completes
                if (early) blank <= 1'b1;
                if (state == WAIT) shift_reg <= rom_q;
                if (strobe) begin
                    if (rep_wrap) begin
                        rep       <= '0;
                        shift_reg <= {shift_reg[LINE_WIDTH-2:0], 1'b0};
                        bit_cnt   <= bit_cnt + BW'(1);
                    end else begin
                        rep <= rep + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_resline_renderer.sv
// Directed bench for resline_renderer: SCALE=1 and SCALE=2 instances share
// one raster; each line is captured per column and compared to a bitmap model.
module tb_resline_renderer;

    localparam int LW = 136;
    localparam int XP = 16;
    localparam int YP = 16;
    localparam int H  = 300;

    logic          clock = 1'b0;
    logic          reset, line_start, de_in;
    logic [11:0]   counterY, counterX;
    logic [3:0]    rom_addr1, rom_addr2;
    logic [LW-1:0] rom_q1, rom_q2;
    logic          pix1, pix2, ferr1, ferr2;
    logic [LW-1:0] rom [16];

    logic [H-1:0]  line1, line2;
    int            ferr1c, ferr2c;
    bit            stray1, stray2;
    int            checks = 0;
    int            errors = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        rom_q1 <= rom[rom_addr1];
        rom_q2 <= rom[rom_addr2];
    end

    resline_renderer #(.LINE_WIDTH(LW), .X_POS(XP), .Y_POS(YP), .SCALE(1)) u_s1 (
        .clock(clock), .reset(reset), .line_start(line_start), .counterY(counterY),
        .counterX(counterX), .de_in(de_in), .rom_addr(rom_addr1), .rom_q(rom_q1),
        .pixel_on(pix1), .fetch_err(ferr1));

    resline_renderer #(.LINE_WIDTH(LW), .X_POS(XP), .Y_POS(YP), .SCALE(2)) u_s2 (
        .clock(clock), .reset(reset), .line_start(line_start), .counterY(counterY),
        .counterX(counterX), .de_in(de_in), .rom_addr(rom_addr2), .rom_q(rom_q2),
        .pixel_on(pix2), .fetch_err(ferr2));

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One pixel clock; outputs sampled 1 time unit after the edge.
    task automatic step(input bit ls, input bit de, input int x);
        line_start = ls;
        de_in      = de;
        counterX   = 12'(x);
        @(posedge clock);
        #1;
        if (de && !ls && x >= 0 && x < H) begin
            line1[x] = pix1;
            line2[x] = pix2;
        end else begin
            if (pix1) stray1 = 1'b1;
            if (pix2) stray2 = 1'b1;
        end
        ferr1c += int'(ferr1);
        ferr2c += int'(ferr2);
    endtask

    task automatic run_line(input int y, input int hb, input int xs, input int xe,
                            input bit gap, input bit ls_de);
        line1  = '0;
        line2  = '0;
        ferr1c = 0;
        ferr2c = 0;
        stray1 = 1'b0;
        stray2 = 1'b0;
        counterY = 12'(y);
        step(1'b1, ls_de, 250);
        repeat (hb) step(1'b0, 1'b0, 0);
        for (int x = xs; x < xe; x++) begin
            step(1'b0, 1'b1, x);
            if (gap && (x % 8) == 7) repeat (3) step(1'b0, 1'b0, x);
        end
        step(1'b0, 1'b0, 0);
    endtask

    function automatic logic [H-1:0] exp_line(input int s, input int y, input int xs, input int xe);
        logic [H-1:0]  e;
        logic [LW-1:0] r;
        e = '0;
        if (y >= YP && y < YP + 16 * s) begin
            r = rom[(y - YP) / s];
            for (int x = xs; x < xe; x++)
                if (x >= XP && x < XP + LW * s) e[x] = r[LW - 1 - (x - XP) / s];
        end
        return e;
    endfunction

    task automatic check_line(input int y, input int xs, input int xe, input bit err);
        logic [H-1:0] e1, e2;
        e1 = err ? '0 : exp_line(1, y, xs, xe);
        e2 = err ? '0 : exp_line(2, y, xs, xe);
        chk($sformatf("pix_s1_y%0d", y), line1, e1);
        chk($sformatf("pix_s2_y%0d", y), line2, e2);
        chk($sformatf("ferr_s1_y%0d", y), ferr1c, err ? 1 : 0);
        chk($sformatf("ferr_s2_y%0d", y), ferr2c, err ? 1 : 0);
        chk($sformatf("stray_y%0d", y), {stray1, stray2}, 2'b00);
    endtask

    task automatic check_addr(input int y);
        int e1, e2;
        e1 = (y < 16) ? 0 : (y < 32) ? y - 16 : 15;
        e2 = (y < 16) ? 0 : (y < 48) ? (y - 16) / 2 : 15;
        chk($sformatf("addr_s1_y%0d", y), rom_addr1, e1);
        chk($sformatf("addr_s2_y%0d", y), rom_addr2, e2);
    endtask

    initial begin
        bit gap, err_line, ls_de;
        int xe;
        reset = 1'b1; line_start = 1'b0; de_in = 1'b0; counterX = '0; counterY = '0;
        for (int r = 0; r < 16; r++)
            for (int i = 0; i < LW; i++) rom[r][i] = (((i * 5 + r * 3) % 7) < 3);
        rom[2][LW-1 -: 8] = 8'hFE;
        repeat (3) @(posedge clock);
        #1;
        chk("reset", {rom_addr1, rom_addr2, pix1, pix2, ferr1, ferr2}, 0);
        reset = 1'b0;

        // above the window
        run_line(15, 4, 0, H, 1'b0, 1'b0);
        check_line(15, 0, H, 1'b0);
        check_addr(15);

        for (int y = 16; y <= 48; y++) begin
            gap      = (y == 21 || y == 22);
            err_line = (y == 25);
            ls_de    = (y == 31);
            xe       = (y == 30) ? 200 : H;
            if (err_line) run_line(y, 0, 16, H, 1'b0, 1'b0);
            else          run_line(y, 4, 0, xe, gap, ls_de);
            check_line(y, err_line ? 16 : 0, xe, err_line);
            check_addr(y);
            if (y == 18) begin
                chk("t1_on_16_22", line1[22:16], 7'h7f);
                chk("t1_off_23", line1[23], 1'b0);
            end
        end

        // reset in the middle of a shifting line
        counterY = 12'd16;
        step(1'b1, 1'b0, 0);
        repeat (4) step(1'b0, 1'b0, 0);
        for (int x = 0; x < 100; x++) step(1'b0, 1'b1, x);
        reset = 1'b1;
        step(1'b0, 1'b1, 100);
        chk("rst_mid_pix", {pix1, pix2}, 2'b00);
        chk("rst_mid_out", {rom_addr1, rom_addr2, ferr1, ferr2}, 0);
        step(1'b0, 1'b1, 101);
        reset = 1'b0;
        for (int y = 16; y <= 17; y++) begin
            run_line(y, 4, 0, H, 1'b0, 1'b0);
            check_line(y, 0, H, 1'b0);
            check_addr(y);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
